// File: rtl/pixel_window_gen.sv
// pixel_window_gen: turns a raster-order pixel stream into 3x3 neighbourhood
// windows using two line buffers and a column-shifting register window.
// Optional feature: define PIXEL_WINDOW_GEN_STATS_EN to add the win_cnt output
// (windows emitted in the current frame).
module pixel_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  Start,
  input  logic                  din_valid,
  input  logic [DATA_W-1:0]     dina,
  output logic                  LOCK,
  output logic                  win_valid,
  output logic [9*DATA_W-1:0]   win_out,
  output logic                  Complete
`ifdef PIXEL_WINDOW_GEN_STATS_EN
  ,
  output logic [31:0]           win_cnt
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;

  // r_lb0 holds row r-1, r_lb1 holds row r-2 (indexed by column)
  logic [DATA_W-1:0]     r_lb0 [IMG_W];
  logic [DATA_W-1:0]     r_lb1 [IMG_W];

  // Two most recent columns of the window: [row][0] = column c-2, [row][1] = column c-1
  logic [DATA_W-1:0]     r_hist_p0 [3][2];

  logic [9*DATA_W-1:0]   r_win_out_p1;
  logic                  r_vld_p1;

  logic                  w_accept;
  logic                  w_start_run;
  logic                  w_last_pix;
  logic                  w_emit;
  logic [DATA_W-1:0]     w_lb0_rd;
  logic [DATA_W-1:0]     w_lb1_rd;
  logic [DATA_W-1:0]     w_col_new [3];
  logic [9*DATA_W-1:0]   w_win_next;

  assign w_accept    = din_valid && (r_state == S_RUN);
  assign w_start_run = (r_state == S_IDLE) && Start;
  assign w_last_pix  = w_accept && (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_emit      = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  assign w_lb0_rd    = r_lb0[r_col];
  assign w_lb1_rd    = r_lb1[r_col];

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    LOCK        = 1'b0;
    Complete    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        LOCK = 1'b1;
        if (w_last_pix) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        Complete = 1'b1;
        if (!Start) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Column/row position of the next pixel to be accepted
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_start_run) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers age by one row at the current column; contents need no reset
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= dina;
    end
  end

  // Assemble the incoming column and the candidate window
  always_comb begin
    w_col_new[0] = w_lb1_rd;
    w_col_new[1] = w_lb0_rd;
    w_col_new[2] = dina;
    w_win_next   = '0;
    for (int i = 0; i < 3; i++) begin
      w_win_next[(3*i+0)*DATA_W +: DATA_W] = r_hist_p0[i][0];
      w_win_next[(3*i+1)*DATA_W +: DATA_W] = r_hist_p0[i][1];
      w_win_next[(3*i+2)*DATA_W +: DATA_W] = w_col_new[i];
    end
  end

  // Window history shifts one column per accepted pixel only
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_hist_p0[i][0] <= r_hist_p0[i][1];
        r_hist_p0[i][1] <= w_col_new[i];
      end
    end
  end

  // ---- stage p0 -> p1: registered window output and its valid pulse ----
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_vld_p1     <= 1'b0;
      r_win_out_p1 <= '0;
    end else begin
      r_vld_p1 <= w_emit;
      if (w_emit) r_win_out_p1 <= w_win_next;
    end
  end

  assign win_valid = r_vld_p1;
  assign win_out   = r_win_out_p1;

`ifdef PIXEL_WINDOW_GEN_STATS_EN
  logic [31:0] r_win_cnt;

  // Count windows emitted in the current frame; cleared when a frame starts
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_win_cnt <= '0;
    end else if (w_start_run) begin
      r_win_cnt <= '0;
    end else if (w_emit) begin
      r_win_cnt <= r_win_cnt + 32'd1;
    end
  end

  assign win_cnt = r_win_cnt;
`endif

endmodule

// File: tb/tb_pixel_window_gen.sv
// tb_pixel_window_gen: directed bench for pixel_window_gen on a 4x4 frame
// of pixels 0x00..0x0F, with continuous and gapped din_valid, reset abort,
// and DONE/IDLE/RUN handshake sequencing.
module tb_pixel_window_gen;

  localparam int DW   = 8;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int NPIX = IW * IH;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            Start = 1'b0;
  logic            din_valid = 1'b0;
  logic [DW-1:0]   dina = '0;
  logic            LOCK;
  logic            win_valid;
  logic [9*DW-1:0] win_out;
  logic            Complete;
`ifdef PIXEL_WINDOW_GEN_STATS_EN
  logic [31:0]     win_cnt;
`endif

  int              checks = 0;
  int              errors = 0;
  logic [71:0]     last_win = '0;
  int              nwin;

  pixel_window_gen #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .IMG_H  (IH)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .Start     (Start),
    .din_valid (din_valid),
    .dina      (dina),
    .LOCK      (LOCK),
    .win_valid (win_valid),
    .win_out   (win_out),
    .Complete  (Complete)
`ifdef PIXEL_WINDOW_GEN_STATS_EN
    ,
    .win_cnt   (win_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected window for accepted pixel p(r,c) where p(r,c) = r*IW + c
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    int          v;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v = (r - 2 + i) * IW + (c - 2 + j);
        w[(i*3+j)*8 +: 8] = 8'(v);
      end
    end
    return w;
  endfunction

  task automatic reset_dut();
    @(negedge CLK);
    RST_N     = 1'b0;
    Start     = 1'b0;
    din_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_lock", 72'(LOCK), 72'(0));
    check("rst_win_valid", 72'(win_valid), 72'(0));
    check("rst_complete", 72'(Complete), 72'(0));
    check("rst_win_out", 72'(win_out), 72'(0));
`ifdef PIXEL_WINDOW_GEN_STATS_EN
    check("rst_win_cnt", 72'(win_cnt), 72'(0));
`endif
    last_win = '0;
    RST_N    = 1'b1;
  endtask

  // Must be entered at a negedge; returns at a negedge.
  task automatic run_frame(input bit gaps, input int stop_at, output int n_out);
    int k;
    int cyc;
    int n;
    int r;
    int c;
    bit v;
    bit acc;
    bit exp_v;
    k   = 0;
    cyc = 0;
    n   = 0;
    while (k < stop_at && cyc < 200) begin
      Start     = 1'b1;
      v         = gaps ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      din_valid = v;
      dina      = v ? 8'(k) : 8'hFF;
      acc       = LOCK && v;
      r         = k / IW;
      c         = k % IW;
      @(posedge CLK);
      @(negedge CLK);
      exp_v = acc && (r >= 2) && (c >= 2);
      if (acc) k++;
      check("win_valid", 72'(win_valid), 72'(exp_v));
      if (exp_v) begin
        last_win = exp_win(r, c);
        n++;
      end
      check("win_out", 72'(win_out), last_win);
      check("complete", 72'(Complete), 72'(k == NPIX));
      cyc++;
    end
    din_valid = 1'b0;
    if (cyc >= 200) check("frame_timeout", 72'(k), 72'(stop_at));
    n_out = n;
  endtask

  initial begin
    reset_dut();

    // Continuous frame
    @(negedge CLK);
    run_frame(1'b0, NPIX, nwin);
    check("nwin_cont", 72'(nwin), 72'(4));
    check("lock_after_done", 72'(LOCK), 72'(0));
    check("last_win_cont", 72'(win_out), 72'(72'h0F_0E_0D_0B_0A_09_07_06_05));
`ifdef PIXEL_WINDOW_GEN_STATS_EN
    check("win_cnt_done", 72'(win_cnt), 72'(4));
`endif

    // Start held in DONE keeps DONE
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      check("done_hold_complete", 72'(Complete), 72'(1));
      check("done_hold_lock", 72'(LOCK), 72'(0));
    end
    Start = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("idle_complete", 72'(Complete), 72'(0));
    check("idle_lock", 72'(LOCK), 72'(0));
    Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("run_lock", 72'(LOCK), 72'(1));
    check("run_complete", 72'(Complete), 72'(0));
`ifdef PIXEL_WINDOW_GEN_STATS_EN
    check("win_cnt_cleared", 72'(win_cnt), 72'(0));
`endif

    // Gapped frame: din_valid 1,0,0,1 repeating
    run_frame(1'b1, NPIX, nwin);
    check("nwin_gaps", 72'(nwin), 72'(4));
    check("lock_after_gaps", 72'(LOCK), 72'(0));

    // Abort after 7 accepted pixels, then a fresh frame
    Start = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    run_frame(1'b0, 7, nwin);
    check("nwin_abort", 72'(nwin), 72'(0));
    reset_dut();
    @(negedge CLK);
    run_frame(1'b0, NPIX, nwin);
    check("nwin_after_rst", 72'(nwin), 72'(4));
    check("lock_after_rst_frame", 72'(LOCK), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
